dcache_direct_wb: RTL and testbench



---
 rtl/dcache_direct_wb_if.sv | 28 ++
 rtl/dcache_direct_wb.sv | 127 ++++++++++++
 tb/tb_dcache_direct_wb.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_direct_wb_if.sv
// Bus bundle between the CPU D-mem port, the data cache and the off-chip data memory.
// The slave modport is the cache's view; master is the CPU/memory environment.
interface dcache_direct_wb_if #(
    parameter int ADDR_W = 30
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
// Hits complete combinationally; misses stall for writeback (if dirty) and refill.
module dcache_direct_wb #(
    parameter int ADDR_W  = 30,
    parameter int INDEX_W = 3
) (
    input logic               clk,
    input logic               rst_n,
    dcache_direct_wb_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int NBLK  = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t            state;
    logic [NBLK-1:0]   valid_q;
    logic [NBLK-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [NBLK];
    logic [127:0]      data_q [NBLK];

    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [127:0]      mem_wdata_q;

    logic [1:0]         offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               request;
    logic               hit;
    logic               wr_hit;
    logic               refill_done;
    logic [31:0]        hit_word;

    assign offset  = bus.proc_addr[1:0];
    assign index   = bus.proc_addr[INDEX_W+1:2];
    assign tag     = bus.proc_addr[ADDR_W-1:INDEX_W+2];
    assign request = bus.proc_read | bus.proc_write;

    always_comb begin
        hit         = valid_q[index] && (tag_q[index] == tag);
        wr_hit      = (state == IDLE) && bus.proc_write && hit;
        refill_done = (state == ALLOCATE) && bus.mem_ready;
        hit_word    = data_q[index][{offset, 5'b00000} +: 32];
    end

    // Stall and read data are masked during reset so an aborted miss releases the CPU at once.
    assign bus.proc_stall = rst_n && request && !((state == IDLE) && hit);
    assign bus.proc_rdata = (rst_n && (state == IDLE) && hit && bus.proc_read && !bus.proc_write)
                            ? hit_word : 32'd0;

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Tag and data arrays carry no reset; validity alone decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            data_q[index] <= bus.mem_rdata;
            tag_q[index]  <= tag;
        end else if (wr_hit) begin
            data_q[index][{offset, 5'b00000} +: 32] <= bus.proc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        if (dirty_q[index]) begin
                            state       <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[index], index};
                            mem_wdata_q <= data_q[index];
                        end else begin
                            state      <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {tag, index};
                        end
                    end else if (wr_hit) begin
                        dirty_q[index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        state       <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {tag, index};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        state          <= IDLE;
                        mem_read_q     <= 1'b0;
                        mem_addr_q     <= '0;
                        valid_q[index] <= 1'b1;
                        dirty_q[index] <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb with a latency-programmable block memory model.
module tb_dcache_direct_wb;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    dcache_direct_wb_if #(.ADDR_W(30)) bus ();

    dcache_direct_wb #(.ADDR_W(30), .INDEX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model state and bus monitors
    logic [127:0] store [logic [27:0]];
    int           lat;
    int           req_cyc;
    int           rd_cycles, wr_cycles, rd_done, wb_done;
    logic [27:0]  req_addr, last_rd_addr, last_wb_addr;
    logic [127:0] req_wd, last_wb_data;
    bit           both_high, unstable;

    function automatic logic [127:0] blk_default(input logic [27:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = 32'hA000_0000 | ({4'd0, b} << 8) | 32'(i);
        return r;
    endfunction

    function automatic logic [127:0] lookup(input logic [27:0] b);
        if (store.exists(b)) return store[b];
        return blk_default(b);
    endfunction

    always @(negedge clk) begin
        if (bus.mem_read && bus.mem_write) both_high = 1'b1;
        if (bus.mem_read || bus.mem_write) begin
            req_cyc++;
            if (req_cyc == 1) begin
                req_addr = bus.mem_addr;
                req_wd   = bus.mem_wdata;
            end else if (bus.mem_addr !== req_addr || (bus.mem_write && bus.mem_wdata !== req_wd)) begin
                unstable = 1'b1;
            end
            if (bus.mem_read) rd_cycles++;
            else wr_cycles++;
            if (req_cyc >= lat) begin
                bus.mem_ready = 1'b1;
                req_cyc = 0;
                if (bus.mem_write) begin
                    store[bus.mem_addr] = bus.mem_wdata;
                    wb_done++;
                    last_wb_addr = bus.mem_addr;
                    last_wb_data = bus.mem_wdata;
                end else begin
                    bus.mem_rdata = lookup(bus.mem_addr);
                    rd_done++;
                    last_rd_addr = bus.mem_addr;
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
        end else begin
            req_cyc = 0;
            bus.mem_ready = 1'b0;
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [29:0] a,
                             input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
        @(negedge clk);
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        #1;
        stalls = 0;
        while (bus.proc_stall === 1'b1 && stalls < 300) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 300) begin
            total++; bad++;
            $display("FAIL access_timeout addr=%h stalled=%0d limit=300", a, stalls);
        end
        rdata = bus.proc_rdata;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.proc_read = 1'b0; bus.proc_write = 1'b0;
        bus.proc_addr = '0; bus.proc_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.proc_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.proc_stall); end
        total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b exp=0", bus.mem_read); end
        total++; if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write); end
        total++; if (bus.mem_addr !== 28'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 128'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
        total++; if (bus.proc_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.proc_rdata); end
    endtask

    task automatic test_cold_read();
        int st; logic [31:0] d; int rc0;
        lat = 3; rc0 = rd_cycles;
        do_access(1'b1, 1'b0, 30'h10, 32'h0, st, d);
        total++; if (st != 4) begin bad++; $display("FAIL cold_stall got=%0d exp=4", st); end
        total++; if (rd_cycles - rc0 != 3) begin bad++; $display("FAIL cold_mem_read_cycles got=%0d exp=3", rd_cycles - rc0); end
        total++; if (last_rd_addr !== 28'h4) begin bad++; $display("FAIL cold_mem_addr got=%h exp=4", last_rd_addr); end
        total++; if (d !== 32'hA000_0400) begin bad++; $display("FAIL cold_rdata got=%h exp=a0000400", d); end
    endtask

    task automatic test_read_hits();
        int st; logic [31:0] d; int rc0;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA000_0401; exp_d[1] = 32'hA000_0402; exp_d[2] = 32'hA000_0403;
        rc0 = rd_cycles;
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 1'b0, 30'h11 + 30'(i), 32'h0, st, d);
            total++; if (st != 0) begin bad++; $display("FAIL hit_stall_%0d got=%0d exp=0", i, st); end
            total++; if (d !== exp_d[i]) begin bad++; $display("FAIL hit_rdata_%0d got=%h exp=%h", i, d, exp_d[i]); end
        end
        total++; if (rd_cycles != rc0) begin bad++; $display("FAIL hit_mem_read got=%0d exp=%0d", rd_cycles, rc0); end
    endtask

    task automatic test_write_evict();
        int st; logic [31:0] d; int wb0;
        lat = 3; wb0 = wb_done; unstable = 1'b0;
        do_access(1'b0, 1'b1, 30'h12, 32'hDEAD_BEEF, st, d);
        total++; if (st != 0) begin bad++; $display("FAIL wr_hit_stall got=%0d exp=0", st); end
        do_access(1'b1, 1'b0, 30'h32, 32'h0, st, d);
        total++; if (st != 7) begin bad++; $display("FAIL evict_stall got=%0d exp=7", st); end
        total++; if (wb_done - wb0 != 1) begin bad++; $display("FAIL evict_wb_count got=%0d exp=1", wb_done - wb0); end
        total++; if (last_wb_addr !== 28'h4) begin bad++; $display("FAIL evict_wb_addr got=%h exp=4", last_wb_addr); end
        total++; if (last_wb_data[95:64] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL evict_wb_word2 got=%h exp=deadbeef", last_wb_data[95:64]); end
        total++; if (last_wb_data[31:0] !== 32'hA000_0400) begin bad++; $display("FAIL evict_wb_word0 got=%h exp=a0000400", last_wb_data[31:0]); end
        total++; if (last_rd_addr !== 28'hC) begin bad++; $display("FAIL evict_rd_addr got=%h exp=c", last_rd_addr); end
        total++; if (d !== 32'hA000_0C02) begin bad++; $display("FAIL evict_rdata got=%h exp=a0000c02", d); end
    endtask

    task automatic test_clean_conflict();
        int st; logic [31:0] d; int wb0, rd0;
        logic [29:0] addrs [3];
        logic [31:0] exp_d [3];
        addrs[0] = 30'h10; addrs[1] = 30'h30; addrs[2] = 30'h10;
        exp_d[0] = 32'hA000_0400; exp_d[1] = 32'hA000_0C00; exp_d[2] = 32'hA000_0400;
        lat = 3; wb0 = wb_done; rd0 = rd_done;
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 1'b0, addrs[i], 32'h0, st, d);
            total++; if (st != 4) begin bad++; $display("FAIL conflict_stall_%0d got=%0d exp=4", i, st); end
            total++; if (d !== exp_d[i]) begin bad++; $display("FAIL conflict_rdata_%0d got=%h exp=%h", i, d, exp_d[i]); end
        end
        total++; if (rd_done - rd0 != 3) begin bad++; $display("FAIL conflict_refills got=%0d exp=3", rd_done - rd0); end
        total++; if (wb_done != wb0) begin bad++; $display("FAIL conflict_writebacks got=%0d exp=0", wb_done - wb0); end
        do_access(1'b1, 1'b0, 30'h12, 32'h0, st, d);
        total++; if (d !== 32'hDEAD_BEEF || st != 0) begin bad++; $display("FAIL persisted_word got=%h/%0d exp=deadbeef/0", d, st); end
    endtask

    task automatic test_reset_mid_alloc();
        int n; int st; logic [31:0] d; int rc0;
        lat = 20;
        @(negedge clk);
        bus.proc_read = 1'b1; bus.proc_write = 1'b0; bus.proc_addr = 30'h20;
        n = 0;
        while (bus.mem_read !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL rst_mid_no_mem_read waited=%0d limit=50", n); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL rst_mid_mem_read got=%b exp=0", bus.mem_read); end
        total++; if (bus.proc_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", bus.proc_stall); end
        bus.proc_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 3; rc0 = rd_cycles;
        do_access(1'b1, 1'b0, 30'h10, 32'h0, st, d);
        total++; if (st != 4) begin bad++; $display("FAIL rst_reread_stall got=%0d exp=4", st); end
        total++; if (rd_cycles - rc0 != 3) begin bad++; $display("FAIL rst_reread_mem_read got=%0d exp=3", rd_cycles - rc0); end
        total++; if (d !== 32'hA000_0400) begin bad++; $display("FAIL rst_reread_rdata got=%h exp=a0000400", d); end
        do_access(1'b1, 1'b0, 30'h20, 32'h0, st, d);
        total++; if (d !== 32'hA000_0800 || st != 4) begin bad++; $display("FAIL rst_aborted_addr got=%h/%0d exp=a0000800/4", d, st); end
    endtask

    task automatic test_long_latency();
        int st; logic [31:0] d; int rc0, wc0;
        lat = 3;
        do_access(1'b0, 1'b1, 30'h10, 32'h1234_5678, st, d);
        total++; if (st != 0) begin bad++; $display("FAIL long_wr_stall got=%0d exp=0", st); end
        do_access(1'b1, 1'b0, 30'h10, 32'h0, st, d);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL long_merge got=%h exp=12345678", d); end
        lat = 20; rc0 = rd_cycles; wc0 = wr_cycles; unstable = 1'b0;
        do_access(1'b1, 1'b0, 30'h30, 32'h0, st, d);
        total++; if (st != 41) begin bad++; $display("FAIL long_stall got=%0d exp=41", st); end
        total++; if (wr_cycles - wc0 != 20) begin bad++; $display("FAIL long_wr_cycles got=%0d exp=20", wr_cycles - wc0); end
        total++; if (rd_cycles - rc0 != 20) begin bad++; $display("FAIL long_rd_cycles got=%0d exp=20", rd_cycles - rc0); end
        total++; if (unstable !== 1'b0) begin bad++; $display("FAIL long_bus_stable got=%b exp=0", unstable); end
        total++; if (last_wb_addr !== 28'h4) begin bad++; $display("FAIL long_wb_addr got=%h exp=4", last_wb_addr); end
        total++; if (last_wb_data[31:0] !== 32'h1234_5678) begin bad++; $display("FAIL long_wb_word0 got=%h exp=12345678", last_wb_data[31:0]); end
        total++; if (last_wb_data[95:64] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL long_wb_word2 got=%h exp=deadbeef", last_wb_data[95:64]); end
        total++; if (d !== 32'hA000_0C00) begin bad++; $display("FAIL long_rdata got=%h exp=a0000c00", d); end
        go_idle();
        #1;
        total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_wdata !== 128'h0) begin
            bad++; $display("FAIL idle_mem_bus got=%b%b/%h exp=00/0", bus.mem_read, bus.mem_write, bus.mem_wdata);
        end
        total++; if (both_high !== 1'b0) begin bad++; $display("FAIL mem_rd_wr_exclusive got=%b exp=0", both_high); end
    endtask

    initial begin
        total = 0; bad = 0;
        lat = 3; req_cyc = 0;
        rd_cycles = 0; wr_cycles = 0; rd_done = 0; wb_done = 0;
        both_high = 1'b0; unstable = 1'b0;
        last_rd_addr = '0; last_wb_addr = '0; last_wb_data = '0;
        req_addr = '0; req_wd = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_cold_read();
        test_read_hits();
        test_write_evict();
        test_clean_conflict();
        test_reset_mid_alloc();
        test_long_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
